// File: rtl/spi_slave_ctrl.sv
// -----------------------------------------------------------------------------
// spi_slave_ctrl
//
// SPI slave front end for a small RAM. Each frame is DATA_W+2 bits, MSB
// first: a 2-bit command followed by DATA_W bits of address or data. Every
// completed frame goes to the RAM on rx_data, qualified by a one-cycle
// rx_valid strobe. A read-data frame then waits for the RAM to answer on
// tx_valid/tx_data and shifts that byte out on MISO.
//
// The slave tracks whether a read address has already been sent. While that
// flag is set, a frame whose first bit is 1 is treated as a read-data frame.
//
// Ports
//   clk       in   single clock, all flops on the rising edge
//   rst_n     in   asynchronous active-low reset
//   SS_n      in   slave select, active low, synchronous to clk
//   MOSI      in   serial data in, MSB first
//   MISO      out  serial data out, MSB first, registered
//   rx_data   out  received frame: [DATA_W+1:DATA_W] command, [DATA_W-1:0] addr/data
//   rx_valid  out  one-cycle strobe qualifying rx_data
//   tx_data   in   read data from RAM
//   tx_valid  in   qualifies tx_data
// -----------------------------------------------------------------------------
module spi_slave_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);

    localparam int FRAME_W = DATA_W + 2;
    localparam int CNT_W   = $clog2(FRAME_W);

    // The bit counter runs 0..DATA_W while frame bits DATA_W..0 arrive.
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W);
    // The MISO counter counts the bits already presented on MISO.
    localparam logic [CNT_W-1:0] TX_BITS  = CNT_W'(DATA_W);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [FRAME_W-1:0] r_rx_sr;
    logic               r_frame_done;   // frame fully received; ignore MOSI until SS_n rises
    logic               r_rd_addr_flag; // read address already sent, next read is data
    logic [DATA_W-1:0]  r_tx_sr;
    logic [CNT_W-1:0]   r_tx_cnt;
    logic               r_tx_busy;      // MISO transfer in progress
    logic               r_tx_done;      // byte already sent this frame; blocks a reload

    // Frame as it stands once the current MOSI bit is shifted in.
    logic [FRAME_W-1:0] w_frame;
    assign w_frame = {r_rx_sr[FRAME_W-2:0], MOSI};

    // NOTE: every flop here, including both shift registers, is cleared by
    // the asynchronous reset so that a reset mid-frame leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_bit_cnt      <= '0;
            r_rx_sr        <= '0;
            r_frame_done   <= 1'b0;
            r_rd_addr_flag <= 1'b0;
            r_tx_sr        <= '0;
            r_tx_cnt       <= '0;
            r_tx_busy      <= 1'b0;
            r_tx_done      <= 1'b0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            MISO           <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch
            // below reads the register values from before this edge.
            rx_valid <= 1'b0;

            if (r_state != IDLE && SS_n) begin
                // Deselect aborts whatever is in flight. This includes the
                // edge that would have sampled bit 0, so the partial frame
                // is dropped without a strobe. rd_addr_flag is left as is.
                r_state      <= IDLE;
                r_bit_cnt    <= '0;
                r_rx_sr      <= '0;
                r_frame_done <= 1'b0;
                r_tx_sr      <= '0;
                r_tx_cnt     <= '0;
                r_tx_busy    <= 1'b0;
                r_tx_done    <= 1'b0;
                MISO         <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        MISO <= 1'b0;
                        if (!SS_n) begin
                            r_state   <= CHK_CMD;
                            r_bit_cnt <= '0;
                        end
                    end

                    CHK_CMD: begin
                        r_rx_sr <= w_frame;
                        if (!MOSI)
                            r_state <= WRITE;
                        else if (r_rd_addr_flag)
                            r_state <= READ_DATA;
                        else
                            r_state <= READ_ADD;
                    end

                    WRITE, READ_ADD, READ_DATA: begin
                        if (!r_frame_done) begin
                            r_rx_sr <= w_frame;
                            if (r_bit_cnt == LAST_BIT) begin
                                rx_data      <= w_frame;
                                rx_valid     <= 1'b1;
                                r_frame_done <= 1'b1;
                                if (r_state == READ_ADD)
                                    r_rd_addr_flag <= 1'b1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            end
                        end else if (r_state == READ_DATA) begin
                            if (r_tx_busy) begin
                                if (r_tx_cnt == TX_BITS) begin
                                    // Last bit has had its cycle on MISO.
                                    MISO           <= 1'b0;
                                    r_tx_busy      <= 1'b0;
                                    r_tx_done      <= 1'b1;
                                    r_rd_addr_flag <= 1'b0;
                                end else begin
                                    MISO     <= r_tx_sr[DATA_W-1];
                                    r_tx_sr  <= r_tx_sr << 1;
                                    r_tx_cnt <= r_tx_cnt + CNT_W'(1);
                                end
                            end else if (!r_tx_done && tx_valid) begin
                                // The MSB goes straight to MISO. The rest waits
                                // in the shift register.
                                MISO      <= tx_data[DATA_W-1];
                                r_tx_sr   <= {tx_data[DATA_W-2:0], 1'b0};
                                r_tx_cnt  <= CNT_W'(1);
                                r_tx_busy <= 1'b1;
                            end
                        end
                    end

                    default: begin
                        r_state <= IDLE;
                        MISO    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_ctrl
//
// Directed bench for spi_slave_ctrl. Inputs change 1 ns after a rising edge.
// Outputs are observed at the same point, which is well away from the next
// active edge. The expected values are written out by hand for each frame.
// -----------------------------------------------------------------------------
module tb_spi_slave_ctrl;

    localparam int DW = 8;

    localparam logic [31:0] S_IDLE      = 32'd0;
    localparam logic [31:0] S_CHK_CMD   = 32'd1;
    localparam logic [31:0] S_WRITE     = 32'd2;
    localparam logic [31:0] S_READ_ADD  = 32'd3;
    localparam logic [31:0] S_READ_DATA = 32'd4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          SS_n;
    logic          MOSI;
    logic          MISO;
    logic [DW+1:0] rx_data;
    logic          rx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_valid;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_byte;

    spi_slave_ctrl #(.DATA_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive frame bits hi..lo, one per clock.
    task automatic shift_bits(input logic [9:0] f, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            MOSI = f[i];
            tick();
        end
    endtask

    // Select the slave. MOSI is set to 1 on this cycle to show that it is ignored.
    task automatic begin_frame();
        SS_n = 1'b0;
        MOSI = 1'b1;
        tick();
    endtask

    task automatic end_frame();
        SS_n = 1'b1;
        MOSI = 1'b0;
        tick();
    endtask

    task automatic send_frame(input logic [9:0] f);
        begin_frame();
        shift_bits(f, 9, 0);
    endtask

    initial begin
        // ---------------- reset ----------------
        rst_n    = 1'b0;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        #12;
        check("rst_miso",     32'(MISO),               32'd0);
        check("rst_rx_data",  32'(rx_data),            32'd0);
        check("rst_rx_valid", 32'(rx_valid),           32'd0);
        check("rst_state",    32'(dut.r_state),        S_IDLE);
        check("rst_flag",     32'(dut.r_rd_addr_flag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ---------------- write frame 00_1010_0101 ----------------
        begin_frame();
        check("wr_chk_cmd", 32'(dut.r_state), S_CHK_CMD);
        shift_bits(10'h0A5, 9, 1);
        check("wr_no_early_valid", 32'(rx_valid), 32'd0);
        check("wr_state", 32'(dut.r_state), S_WRITE);
        shift_bits(10'h0A5, 0, 0);
        check("wr_valid",   32'(rx_valid), 32'd1);
        check("wr_rx_data", 32'(rx_data),  32'h0A5);
        MOSI = 1'b1;
        tick();
        check("wr_valid_one_cycle", 32'(rx_valid), 32'd0);
        MOSI = 1'b0;
        tick();
        MOSI = 1'b1;
        tick();
        check("wr_hold_state", 32'(dut.r_state), S_WRITE);
        check("wr_hold_data",  32'(rx_data),      32'h0A5);
        check("wr_no_revalid", 32'(rx_valid),     32'd0);
        end_frame();
        check("wr_idle", 32'(dut.r_state), S_IDLE);

        // ---------------- tx_valid during write frame is ignored ----------------
        begin_frame();
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        shift_bits(10'h0FF, 9, 5);
        check("txw_miso_mid", 32'(MISO), 32'd0);
        shift_bits(10'h0FF, 4, 0);
        check("txw_rx_data", 32'(rx_data), 32'h0FF);
        tick();
        check("txw_miso_after1", 32'(MISO), 32'd0);
        tick();
        check("txw_miso_after2", 32'(MISO), 32'd0);
        tx_valid = 1'b0;
        end_frame();

        // ---------------- command 01 frame ----------------
        send_frame(10'h13C);
        check("c01_valid",   32'(rx_valid),           32'd1);
        check("c01_rx_data", 32'(rx_data),            32'h13C);
        check("c01_flag",    32'(dut.r_rd_addr_flag), 32'd0);
        tick();
        check("c01_valid_off", 32'(rx_valid), 32'd0);
        end_frame();

        // ---------------- read address then read data ----------------
        send_frame(10'h2A5);
        check("ra_valid",   32'(rx_valid),           32'd1);
        check("ra_rx_data", 32'(rx_data),            32'h2A5);
        check("ra_state",   32'(dut.r_state),        S_READ_ADD);
        check("ra_flag",    32'(dut.r_rd_addr_flag), 32'd1);
        end_frame();
        begin_frame();
        shift_bits(10'h300, 9, 9);
        check("rd_state", 32'(dut.r_state), S_READ_DATA);
        shift_bits(10'h300, 8, 0);
        check("rd_valid",   32'(rx_valid),           32'd1);
        check("rd_rx_data", 32'(rx_data),            32'h300);
        check("rd_flag_kept", 32'(dut.r_rd_addr_flag), 32'd1);
        check("rd_miso_wait", 32'(MISO), 32'd0);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        exp_byte = 8'h3C;
        for (int i = 7; i >= 0; i--) begin
            tick();
            check($sformatf("rd_miso_bit%0d", i), 32'(MISO), 32'(exp_byte[i]));
        end
        tick();
        check("rd_miso_end", 32'(MISO),               32'd0);
        check("rd_flag_clr", 32'(dut.r_rd_addr_flag), 32'd0);
        tick();
        tick();
        check("rd_no_reload", 32'(MISO), 32'd0);
        tx_valid = 1'b0;
        end_frame();

        // ---------------- abort after 5 bits ----------------
        begin_frame();
        shift_bits(10'h155, 9, 5);
        SS_n = 1'b1;
        tick();
        check("ab5_valid",   32'(rx_valid),      32'd0);
        check("ab5_state",   32'(dut.r_state),   S_IDLE);
        check("ab5_rx_data", 32'(rx_data),       32'h300);
        check("ab5_bit_cnt", 32'(dut.r_bit_cnt), 32'd0);

        // ---------------- abort on the bit-0 cycle ----------------
        begin_frame();
        shift_bits(10'h0C3, 9, 1);
        SS_n = 1'b1;
        MOSI = 1'b1;
        tick();
        check("ab0_valid",   32'(rx_valid),    32'd0);
        check("ab0_state",   32'(dut.r_state), S_IDLE);
        check("ab0_rx_data", 32'(rx_data),     32'h300);
        tick();
        check("ab0_valid_late", 32'(rx_valid), 32'd0);

        // ---------------- abort during MISO transfer ----------------
        send_frame(10'h2A5);
        end_frame();
        send_frame(10'h3FF);
        check("abtx_rx_data", 32'(rx_data), 32'h3FF);
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        tick();
        check("abtx_b7", 32'(MISO), 32'd1);
        tick();
        check("abtx_b6", 32'(MISO), 32'd0);
        tick();
        check("abtx_b5", 32'(MISO), 32'd1);
        SS_n     = 1'b1;
        tx_valid = 1'b0;
        tick();
        check("abtx_miso",  32'(MISO),               32'd0);
        check("abtx_state", 32'(dut.r_state),        S_IDLE);
        check("abtx_flag",  32'(dut.r_rd_addr_flag), 32'd1);

        // ---------------- async reset during MISO transfer ----------------
        begin_frame();
        shift_bits(10'h300, 9, 9);
        check("rst_tx_state", 32'(dut.r_state), S_READ_DATA);
        shift_bits(10'h300, 8, 0);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        tick();
        tick();
        check("rst_tx_miso_pre", 32'(MISO), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_miso",     32'(MISO),               32'd0);
        check("arst_rx_data",  32'(rx_data),            32'd0);
        check("arst_rx_valid", 32'(rx_valid),           32'd0);
        check("arst_flag",     32'(dut.r_rd_addr_flag), 32'd0);
        check("arst_state",    32'(dut.r_state),        S_IDLE);
        tx_valid = 1'b0;
        SS_n     = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send_frame(10'h13C);
        check("post_rst_valid",   32'(rx_valid),    32'd1);
        check("post_rst_rx_data", 32'(rx_data),     32'h13C);
        check("post_rst_state",   32'(dut.r_state), S_WRITE);
        end_frame();

        // ---------------- reset mid-frame, SS_n held low across release ----------------
        begin_frame();
        shift_bits(10'h2A5, 9, 6);
        #2;
        rst_n = 1'b0;
        #1;
        check("mfrst_state", 32'(dut.r_state), S_IDLE);
        MOSI = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("mfrst_restart", 32'(dut.r_state), S_CHK_CMD);
        shift_bits(10'h0A5, 9, 0);
        check("mfrst_valid",   32'(rx_valid), 32'd1);
        check("mfrst_rx_data", 32'(rx_data),  32'h0A5);
        end_frame();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_ctrl.md
SPI_SLAVE_CTRL -- requirements
Module: spi_slave_ctrl

Interface
REQ-001: Parameter DATA_W, default 8, is the RAM data/address width; frame width is DATA_W+2.
REQ-002: clk  input  1  single clock; all flops rise on posedge clk.
REQ-003: rst_n  input  1  asynchronous active-low reset.
REQ-004: SS_n  input  1  slave select, active low, synchronous to clk.
REQ-005: MOSI  input  1  serial data in, MSB first, sampled on posedge clk.
REQ-006: MISO  output  1  serial data out, MSB first, registered.
REQ-007: rx_data  output  DATA_W+2  received frame to RAM; [9:8] command, [7:0] address/data.
REQ-008: rx_valid  output  1  one-cycle strobe qualifying rx_data.
REQ-009: tx_data  input  DATA_W  read data from RAM.
REQ-010: tx_valid  input  1  qualifies tx_data.

Function
REQ-011: FSM states SHALL be IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-012: IDLE -> CHK_CMD when SS_n sampled 0; MOSI ignored that cycle.
REQ-013: CHK_CMD samples MOSI as frame bit 9; 0 -> WRITE; 1 with rd_addr_flag=0 -> READ_ADD; 1 with rd_addr_flag=1 -> READ_DATA.
REQ-014: WRITE, READ_ADD, READ_DATA shift frame bits 8..0 over the next 9 cycles via a 4-bit bit counter.
REQ-015: Cycle after bit 0 is sampled: rx_data <= full 10-bit frame, rx_valid=1 for exactly one cycle; frame bits forwarded unmodified.
REQ-016: rx_data holds its value until the next completed frame.
REQ-017: rd_addr_flag set on completion of a READ_ADD frame; cleared on completion of the READ_DATA MISO transfer.
REQ-018: After frame completion in WRITE or READ_ADD, state holds, MOSI ignored, until SS_n=1.
REQ-019: READ_DATA after frame completion waits for tx_valid=1; on first such cycle tx_data is loaded into an 8-bit output shift register.
REQ-020: Following 8 cycles MISO = tx_data[7]..tx_data[0], one bit per cycle; MISO=0 at all other times.
REQ-021: tx_valid while not waiting (REQ-019) SHALL be ignored; tx_valid held high loads only once per frame.
REQ-022: SS_n=1 in any non-IDLE state -> IDLE next cycle; bit counter cleared; MISO=0; partial frame discarded, no rx_valid.
REQ-023: SS_n rising on the cycle bit 0 is sampled: abort wins, no rx_valid.
REQ-024: SS_n rising during MISO transfer: transfer aborted, rd_addr_flag remains 1.
REQ-025: rd_addr_flag unaffected by aborts in WRITE or READ_ADD.
REQ-026: Consecutive frames require SS_n=1 for at least one cycle between them.

Reset
REQ-027: rst_n=0 asynchronously forces state=IDLE, rx_data=0, rx_valid=0, MISO=0, rd_addr_flag=0, counters and shift registers 0.
REQ-028: Reset mid-frame discards the frame; first frame after deassertion starts from IDLE.

Verification
REQ-029: SS_n low, MOSI 00_1010_0101 -> rx_data=10'h0A5, rx_valid one cycle, state WRITE until SS_n high.
REQ-030: Frame 01_0011_1100 -> rx_data=10'h13C, rx_valid one cycle, rd_addr_flag unchanged (0).
REQ-031: Frame 10_1010_0101 -> rx_data=10'h2A5, rd_addr_flag=1; next frame 11_0000_0000 -> CHK_CMD->READ_DATA, rx_data=10'h300; tx_valid with tx_data=8'h3C -> MISO 0,0,1,1,1,1,0,0 over 8 cycles, then rd_addr_flag=0.
REQ-032: SS_n high after 5 frame bits -> no rx_valid, IDLE next cycle, rx_data keeps prior value.
REQ-033: rst_n low mid-MISO transfer -> MISO=0 and all outputs reset immediately without clock edge; rd_addr_flag=0.
REQ-034: tx_valid pulsed during WRITE frame -> ignored; MISO stays 0.
